// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types, default parameters and grant search for dram_read_arbiter
package dram_arb_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int AW_DEF          = 32;
   localparam int DW_DEF          = 128;
   localparam int OUTSTANDING_DEF = 8;
   localparam int N_REQ_MAX       = 8;

   // Sized for the largest legal requester count so one type serves every build
   typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;

   function automatic logic [N_REQ_MAX-1:0] rr_pick(
      input logic [N_REQ_MAX-1:0] req,
      input tag_t                 ptr,
      input int                   n
   );
      logic [N_REQ_MAX-1:0] gnt;
      logic                 found;
      int                   idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ_MAX; i++) begin
         idx = (int'(ptr) + i) % n;
         if (i < n && !found && req[tag_t'(idx)]) begin
            gnt[tag_t'(idx)] = 1'b1;
            found            = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// rtl/dram_arb_tag_fifo.sv - in-order FIFO of requester tags for issued DRAM reads
module dram_arb_tag_fifo
   import dram_arb_pkg::*;
#(
   parameter int DEPTH = OUTSTANDING_DEF,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  tag_t        push_tag,
   input  logic        pop,
   output tag_t        head,
   output logic        empty,
   output logic [PW:0] count
);

   tag_t        mem [DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;

   // One extra pointer bit separates full (MSBs differ) from empty (all equal)
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[PW-1:0]] <= push_tag;
   end

endmodule

// File: rtl/dram_read_arbiter.sv
// rtl/dram_read_arbiter.sv - shares the DRAM read channels among N_REQ requesters, data steered back in order
// Build option DRAM_ARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
module dram_read_arbiter
   import dram_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int OUTSTANDING = OUTSTANDING_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [N_REQ-1:0]    req_ra_rdy,
   output logic [N_REQ-1:0]    req_ra_ack,
   input  logic [N_REQ*AW-1:0] req_ra_addr,
   output logic                dramra_rdy,
   input  logic                dramra_ack,
   output logic [AW-1:0]       dramra_addr,
   input  logic                dramrd_rdy,
   output logic                dramrd_ack,
   input  logic [DW-1:0]       dramrd_data,
   output logic [N_REQ-1:0]    req_rd_rdy,
   input  logic [N_REQ-1:0]    req_rd_ack,
   output logic [DW-1:0]       req_rd_data
);

   localparam int CW = $clog2(OUTSTANDING) + 1;

   logic                 hold_vld;
   logic [AW-1:0]        hold_addr;
   tag_t                 hold_tag;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_empty;
   tag_t                 head;
   logic [CW:0]          inflight;
   logic                 capture_ok;
   tag_t                 search_start;
   logic [N_REQ_MAX-1:0] pick;
   tag_t                 win_idx;
   logic [AW-1:0]        win_addr;
   logic [N_REQ-1:0]     head_onehot;
   logic                 push;
   logic                 pop;

   // Start-of-cycle occupancy only: a pop in this cycle does not free a slot until the next
   assign inflight   = {1'b0, fifo_count} + {{CW{1'b0}}, hold_vld};
   assign capture_ok = (!hold_vld || dramra_ack) && (inflight < (CW+1)'(OUTSTANDING));
   assign pick       = rr_pick(N_REQ_MAX'(req_ra_rdy), search_start, N_REQ);

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_REQ_MAX; i++)
         if (pick[i])
            win_idx = tag_t'(i);
   end

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < N_REQ; i++)
         if (pick[i])
            win_addr = req_ra_addr[i*AW +: AW];
   end

   assign req_ra_ack = (i_rst && capture_ok) ? pick[N_REQ-1:0] : '0;

`ifdef DRAM_ARB_FIXED_PRIO_EN
   assign search_start = '0;
`else
   tag_t rr_ptr;

   assign search_start = rr_ptr;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         rr_ptr <= '0;
      else if (|req_ra_ack)
         rr_ptr <= (win_idx == tag_t'(N_REQ-1)) ? '0 : win_idx + tag_t'(1);
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         hold_vld  <= 1'b0;
         hold_addr <= '0;
         hold_tag  <= '0;
      end else if (|req_ra_ack) begin
         hold_vld  <= 1'b1;
         hold_addr <= win_addr;
         hold_tag  <= win_idx;
      end else if (dramra_ack) begin
         hold_vld  <= 1'b0;
      end
   end

   assign dramra_rdy  = hold_vld;
   assign dramra_addr = hold_addr;
   assign push        = hold_vld && dramra_ack;

   // Return path is purely combinational from the oldest outstanding tag
   assign head_onehot = N_REQ'(1) << head;
   assign req_rd_rdy  = (dramrd_rdy && !fifo_empty) ? head_onehot : '0;
   assign dramrd_ack  = !fifo_empty && |(req_rd_ack & head_onehot);
   assign pop         = dramrd_rdy && dramrd_ack;
   assign req_rd_data = dramrd_data;

   dram_arb_tag_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk      (i_clk),
      .rst_n    (i_rst),
      .push     (push),
      .push_tag (hold_tag),
      .pop      (pop),
      .head     (head),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb/tb_dram_read_arbiter.sv - randomized and directed bench for dram_read_arbiter against a queue model
module tb_dram_read_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 128;
   localparam int OST = 8;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b0;
   logic [N-1:0]    req_ra_rdy = '0;
   logic [N-1:0]    req_ra_ack;
   logic [N*AW-1:0] req_ra_addr = '0;
   logic            dramra_rdy;
   logic            dramra_ack = 1'b0;
   logic [AW-1:0]   dramra_addr;
   logic            dramrd_rdy = 1'b0;
   logic            dramrd_ack;
   logic [DW-1:0]   dramrd_data = '0;
   logic [N-1:0]    req_rd_rdy;
   logic [N-1:0]    req_rd_ack = '0;
   logic [DW-1:0]   req_rd_data;

   always #5 i_clk = ~i_clk;

   dram_read_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .OUTSTANDING(OST)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .req_ra_rdy  (req_ra_rdy),
      .req_ra_ack  (req_ra_ack),
      .req_ra_addr (req_ra_addr),
      .dramra_rdy  (dramra_rdy),
      .dramra_ack  (dramra_ack),
      .dramra_addr (dramra_addr),
      .dramrd_rdy  (dramrd_rdy),
      .dramrd_ack  (dramrd_ack),
      .dramrd_data (dramrd_data),
      .req_rd_rdy  (req_rd_rdy),
      .req_rd_ack  (req_rd_ack),
      .req_rd_data (req_rd_data)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: one-deep skid slot, queue of issued tags, next search start
   int            tagq[$];
   int            grants[$];
   bit            m_vld;
   logic [AW-1:0] m_addr;
   int            m_tag;
   int            m_ptr;
   logic [AW-1:0] addr_of [N];
   bit            keep_req;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_grant(input int k);
`ifdef DRAM_ARB_FIXED_PRIO_EN
      return 0 + 0 * k;
`else
      return k % N;
`endif
   endfunction

   task automatic model_clear();
      tagq.delete();
      grants.delete();
      m_vld  = 1'b0;
      m_addr = '0;
      m_tag  = 0;
      m_ptr  = 0;
   endtask

   // Entered at a negedge with inputs set; compares, then advances the model over one posedge
   task automatic run_cycle();
      int           inflight;
      int           w;
      int           start;
      int           idx;
      bit           cap;
      bit           e_rdack;
      logic [N-1:0] e_ack;
      logic [N-1:0] e_rdrdy;
      for (int i = 0; i < N; i++)
         req_ra_addr[i*AW +: AW] = addr_of[i];
      #1;
      inflight = tagq.size() + int'(m_vld);
      cap      = (!m_vld || dramra_ack) && (inflight < OST);
`ifdef DRAM_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      w = -1;
      if (cap) begin
         for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (w < 0 && req_ra_rdy[idx])
               w = idx;
         end
      end
      e_ack   = (w >= 0) ? (N'(1) << w) : '0;
      e_rdrdy = '0;
      e_rdack = 1'b0;
      if (tagq.size() > 0) begin
         e_rdrdy[tagq[0]] = dramrd_rdy;
         e_rdack          = req_rd_ack[tagq[0]];
      end
      check("req_ra_ack", req_ra_ack, e_ack);
      check("dramra_rdy", dramra_rdy, m_vld);
      if (m_vld)
         check("dramra_addr", dramra_addr, m_addr);
      check("req_rd_rdy", req_rd_rdy, e_rdrdy);
      check("dramrd_ack", dramrd_ack, e_rdack);
      check("req_rd_data", req_rd_data, dramrd_data);
      @(posedge i_clk);
      if (dramrd_rdy && e_rdack)
         void'(tagq.pop_front());
      if (m_vld && dramra_ack)
         tagq.push_back(m_tag);
      if (w >= 0) begin
         m_vld  = 1'b1;
         m_addr = addr_of[w];
         m_tag  = w;
         m_ptr  = (w + 1) % N;
         grants.push_back(w);
      end else if (dramra_ack) begin
         m_vld = 1'b0;
      end
      @(negedge i_clk);
      if (w >= 0 && !keep_req)
         req_ra_rdy[w] = 1'b0;
   endtask

   task automatic do_reset();
      i_rst      = 1'b0;
      req_ra_rdy = '0;
      dramra_ack = 1'b0;
      dramrd_rdy = 1'b0;
      req_rd_ack = '0;
      keep_req   = 1'b0;
      model_clear();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
   endtask

   logic [N-1:0] ret_exp [3];
   int           rd_bias;

   initial begin
      for (int i = 0; i < N; i++)
         addr_of[i] = $urandom;
      model_clear();
      keep_req = 1'b0;

      // Reset state with stimulus asserted
      @(negedge i_clk);
      req_ra_rdy = '1;
      dramrd_rdy = 1'b1;
      dramra_ack = 1'b1;
      req_rd_ack = '1;
      #1;
      check("rst_req_ra_ack", req_ra_ack, '0);
      check("rst_dramra_rdy", dramra_rdy, 1'b0);
      check("rst_dramra_addr", dramra_addr, '0);
      check("rst_dramrd_ack", dramrd_ack, 1'b0);
      check("rst_req_rd_rdy", req_rd_rdy, '0);
      @(negedge i_clk);
      do_reset();

      // Single request from requester 2
      addr_of[2] = 32'h1000;
      req_ra_rdy = 4'b0100;
      dramra_ack = 1'b1;
      run_cycle();
      check("single_addr", dramra_addr, 32'h1000);
      check("single_rdy", dramra_rdy, 1'b1);
      run_cycle();
      dramrd_rdy  = 1'b1;
      dramrd_data = {16{8'hAB}};
      req_rd_ack  = 4'b0100;
      #1;
      check("single_rd_rdy", req_rd_rdy, 4'b0100);
      check("single_rd_data", req_rd_data, {16{8'hAB}});
      run_cycle();

      // All requesters held: one grant per cycle in round-robin order
      do_reset();
      keep_req   = 1'b1;
      req_ra_rdy = '1;
      dramra_ack = 1'b1;
      dramrd_rdy = 1'b1;
      req_rd_ack = '1;
      for (int k = 0; k < 6; k++)
         run_cycle();
      check("rr_count", grants.size(), 6);
      for (int k = 0; k < 6 && k < grants.size(); k++)
         check("rr_order", grants[k], exp_grant(k));

      // Fill to OUTSTANDING with no returns, then one pop
      do_reset();
      keep_req   = 1'b1;
      req_ra_rdy = '1;
      dramra_ack = 1'b1;
      for (int k = 0; k < 20; k++)
         run_cycle();
      check("fill_grants", grants.size(), OST);
      dramrd_rdy = 1'b1;
      req_rd_ack = '1;
      run_cycle();
      check("no_grant_pop_cycle", grants.size(), OST);
      dramrd_rdy = 1'b0;
      run_cycle();
      check("grant_after_pop", grants.size(), OST + 1);

      // Requests 3,1,3 return in order; requester 3 withholding ack stalls return
      do_reset();
      dramra_ack = 1'b1;
      req_ra_rdy = 4'b1000; run_cycle();
      req_ra_rdy = 4'b0010; run_cycle();
      req_ra_rdy = 4'b1000; run_cycle();
      run_cycle();
      run_cycle();
      dramrd_rdy = 1'b1;
      req_rd_ack = 4'b0111;
      #1;
      check("stall_ack", dramrd_ack, 1'b0);
      check("stall_rd_rdy", req_rd_rdy, 4'b1000);
      run_cycle();
      run_cycle();
      req_rd_ack = '1;
      ret_exp[0] = 4'b1000;
      ret_exp[1] = 4'b0010;
      ret_exp[2] = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("return_order", req_rd_rdy, ret_exp[k]);
         run_cycle();
      end

      // Read data with nothing outstanding is never acked
      do_reset();
      dramrd_rdy = 1'b1;
      req_rd_ack = '1;
      for (int k = 0; k < 10; k++) begin
         dramrd_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         check("empty_ack", dramrd_ack, 1'b0);
         check("empty_rd_rdy", req_rd_rdy, '0);
         run_cycle();
      end

      // Asynchronous reset with five requests in flight
      do_reset();
      keep_req   = 1'b1;
      req_ra_rdy = '1;
      dramra_ack = 1'b1;
      for (int k = 0; k < 5; k++)
         run_cycle();
      check("midrst_inflight", tagq.size() + int'(m_vld), 5);
      dramrd_rdy = 1'b1;
      #2;
      i_rst = 1'b0;
      #1;
      check("midrst_req_ra_ack", req_ra_ack, '0);
      check("midrst_dramra_rdy", dramra_rdy, 1'b0);
      check("midrst_dramra_addr", dramra_addr, '0);
      check("midrst_req_rd_rdy", req_rd_rdy, '0);
      check("midrst_dramrd_ack", dramrd_ack, 1'b0);
      model_clear();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst      = 1'b1;
      keep_req   = 1'b0;
      dramrd_rdy = 1'b0;
      req_ra_rdy = 4'b1010;
      run_cycle();
      check("post_rst_grant", grants.size() > 0 ? grants[grants.size()-1] : -1, 1);

      // Randomized traffic in blocks of varying return pressure
      do_reset();
      for (int blk = 0; blk < 10; blk++) begin
         rd_bias = blk % 3;
         for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
               if (!req_ra_rdy[i] && $urandom_range(0, 2) == 0) begin
                  req_ra_rdy[i] = 1'b1;
                  addr_of[i]    = $urandom;
               end
            end
            dramra_ack  = ($urandom_range(0, 3) != 0);
            case (rd_bias)
               0:       dramrd_rdy = ($urandom_range(0, 15) == 0);
               1:       dramrd_rdy = ($urandom_range(0, 1) == 0);
               default: dramrd_rdy = ($urandom_range(0, 9) != 0);
            endcase
            dramrd_data = {$urandom, $urandom, $urandom, $urandom};
            req_rd_ack  = ($urandom_range(0, 3) != 0) ? '1 : N'($urandom_range(0, 15));
            run_cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
